// File: rtl/frame_column_loader.sv
// ============================================================================
// Module      : frame_column_loader
// Description : Collects one configuration frame per column from a 32-bit
//               bitstream stream and pulses a one-hot FrameStrobe to the tiles.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_column_loader #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int ColumnId        = 0,
  parameter int StrobeCycles    = 1
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [31:0]                         WriteData,
  input  logic                                WriteValid,
  output logic                                WriteReady,
  output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                Busy,
  output logic                                AddrError,
  output logic [15:0]                         FrameCount
);

  localparam int          ROW_W      = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);
  localparam logic [5:0]  MAX_FRAMES = 6'(MaxFramesPerCol);
  localparam logic [7:0]  COL_ID     = 8'(ColumnId);
  localparam logic [1:0]  SC_LAST    = 2'(StrobeCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic                                 ready_q, ready_d;
  logic [4:0]                           idx_q, idx_d;
  logic                                 match_q, match_d;
  logic [ROW_W-1:0]                     row_q, row_d;
  logic [1:0]                           scnt_q, scnt_d;
  logic [FrameBitsPerRow*NumRows-1:0]   frame_q, frame_d;
  logic [MaxFramesPerCol-1:0]           strobe_q, strobe_d;
  logic                                 err_q, err_d;
  logic [15:0]                          count_q, count_d;
  logic                                 accept;

  assign accept = WriteValid & ready_q;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      idx_q    <= '0;
      match_q  <= 1'b0;
      row_q    <= '0;
      scnt_q   <= '0;
      frame_q  <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      row_q    <= row_d;
      scnt_q   <= scnt_d;
      frame_q  <= frame_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    match_d  = match_q;
    row_d    = row_q;
    scnt_d   = scnt_q;
    frame_d  = frame_q;
    strobe_d = strobe_q;
    err_d    = err_q;
    count_d  = count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && WriteData[31]) begin
          idx_d   = WriteData[4:0];
          match_d = (WriteData[15:8] == COL_ID) && ({1'b0, WriteData[4:0]} < MAX_FRAMES);
          if ((WriteData[15:8] == COL_ID) && ({1'b0, WriteData[4:0]} >= MAX_FRAMES))
            err_d = 1'b1;
          row_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Non-matching frames still consume their words to keep the stream aligned.
          if (match_q) begin
            for (int r = 0; r < NumRows; r++) begin
              if (row_q == ROW_W'(r))
                frame_d[r*FrameBitsPerRow +: FrameBitsPerRow] = WriteData[FrameBitsPerRow-1:0];
            end
          end
          row_d = row_q + ROW_W'(1);
          if (row_q == LAST_ROW) begin
            if (match_q) begin
              state_d  = ST_STROBE;
              strobe_d = MaxFramesPerCol'(1) << idx_q;
              scnt_d   = '0;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end
      end
      ST_STROBE: begin
        if (scnt_q == SC_LAST) begin
          strobe_d = '0;
          state_d  = ST_HOLD;
        end else begin
          scnt_d   = scnt_q + 2'd1;
        end
      end
      ST_HOLD: begin
        count_d = count_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  assign WriteReady  = ready_q;
  assign FrameData   = frame_q;
  assign FrameStrobe = strobe_q;
  assign Busy        = (state_q != ST_IDLE);
  assign AddrError   = err_q;
  assign FrameCount  = count_q;

endmodule

`default_nettype wire
